alu_result_writeback: RTL and testbench
=======================================

Name: alu_result_writeback

Overview:
- Consumer end of the ALU result path: captures the 64-bit ALU result `z` plus its opcode and destination index on a valid strobe.
- Routes the result to one of four places:
  - register file, via a ready handshake;
  - HI/LO register pair (mul/div);
  - PC (branch);
  - MAR (load/store effective address).
- Also services mfhi/mflo from the internal HI/LO.
- Sits between the ALU output and the datapath write ports, in place of a plain Z register.

Parameters:
- DATA_W, 32, datapath word width; `z` is 2*DATA_W.
- REG_AW, 4, register index width (16 GPRs).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- z_valid  in  1  result strobe; sampled only in IDLE.
- opcode  in  5  ALU opcode, same encoding as the ALU.
- z  in  2*DATA_W  ALU result.
- dest  in  REG_AW  destination GPR index.
- wb_ready  in  1  register file accepts the write this cycle.
- rf_we  out  1  GPR write request.
- rf_waddr  out  REG_AW  GPR write index.
- wb_data  out  DATA_W  shared write data (GPR/PC/MAR).
- pc_we  out  1  PC load strobe.
- mar_we  out  1  MAR load strobe.
- hi_out  out  DATA_W  HI register.
- lo_out  out  DATA_W  LO register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (clr=1, async): state=IDLE; HI=LO=0; latched z/opcode/dest=0; all outputs 0. Reset mid-operation abandons the transaction with no partial write.
- States: IDLE, WRITE, WR_LO, WR_HI, DONE. Outputs are Moore-decoded from state and latched fields.
- IDLE: on z_valid=1, latch z, opcode and dest at the edge.
  - Next state is WR_LO for mul(01111) and div(10000).
  - Next state is DONE for nop, halt, out, jr, jal, in, and undefined codes (no write).
  - Next state is WRITE for everything else.
- WRITE, GPR class (loadi, add, sub, and, or, shr, shra, shl, ror, rol, addi, andi, ori, neg, not, mfhi, mflo):
  - rf_we=1, rf_waddr=dest.
  - wb_data = z[DATA_W-1:0], or HI for mfhi(11000), or LO for mflo(11001).
  - Hold until wb_ready=1; transfer occurs on that edge, then go to DONE.
  - wb_ready may already be high on the first WRITE cycle (1-cycle write).
- WRITE, load(00000)/store(00010): mar_we=1 for exactly one cycle, wb_data=z low word, then DONE. No handshake.
- WRITE, branch(10011): pc_we=1 for one cycle, wb_data=z low word (ALU already selects target vs. fall-through), then DONE.
- WR_LO: LO <= z[DATA_W-1:0] at the edge, then WR_HI.
- WR_HI: HI <= z[2*DATA_W-1:DATA_W], then DONE. HI/LO never change at any other time.
- DONE: done=1 for one cycle, then IDLE.
- busy and z_valid:
  - busy=1 from the edge that accepts z_valid through the DONE cycle.
  - z_valid while busy is ignored and not queued.
- Latency from the accepting edge to done=1:
  - 2 cycles for GPR ops with wb_ready=1, plus 1 cycle per wb_ready=0 cycle.
  - 2 cycles for PC/MAR ops.
  - 3 cycles for mul/div.
  - 1 cycle for no-write ops.
- Outputs outside their active state:
  - rf_we, pc_we and mar_we are 0 outside WRITE.
  - wb_data=0 in IDLE.
  - At most one of rf_we/pc_we/mar_we is high in any cycle.
- mfhi/mflo issued back-to-back after mul/div read the updated HI/LO, since HI is written before DONE.

Optional Feature:
- Macro: R0_LOCK_EN.
- Defined: GPR-class ops with dest=0 skip the handshake.
  - rf_we stays 0; state goes WRITE→DONE in one cycle regardless of wb_ready.
  - done still pulses.
- Undefined: dest=0 is written like any other GPR.

Test Plan:
- Reset: assert clr mid-WR_LO of a mul → hi_out=lo_out=0, busy=0, rf_we=0 immediately, no done pulse.
- add, z=64'h0000_0000_0000_0007, dest=5, wb_ready held 0 for 3 cycles then 1 → rf_we=1 for 4 cycles, rf_waddr=5, wb_data=32'h7, done 1 cycle after the transfer edge.
- mul, z=64'h1234_5678_9ABC_DEF0 → lo_out=32'h9ABC_DEF0 at WR_LO edge, hi_out=32'h1234_5678 one edge later, rf_we never asserted, done at accept+3.
- mfhi then mflo, immediately after that mul, dest=2 then 3 → writes 32'h1234_5678 to r2 and 32'h9ABC_DEF0 to r3.
- branch, z low=32'h0000_0040 → pc_we exactly 1 cycle with wb_data=32'h40. store with z low=32'h0000_0087 → mar_we 1 cycle with wb_data=32'h87. z_valid pulsed during busy → no second transaction.
- R0_LOCK_EN defined, addi dest=0, wb_ready=0 → rf_we stays 0, done at accept+2. Macro undefined → rf_we asserts and waits for wb_ready.

Source files
------------

// File: rtl/alu_result_writeback.sv
// ---------------------------------------------------------------------------
// alu_result_writeback
//
// Consumer end of the ALU result path. It captures the 2*DATA_W-bit ALU
// result together with its opcode and destination index, then routes it to
// the GPR file (ready handshake), the HI/LO pair (mul/div), the PC (branch)
// or the MAR (load/store effective address). mfhi/mflo are serviced from the
// internal HI/LO registers.
//
// Ports:
//   clk       in   system clock, rising edge
//   clr       in   asynchronous active-high reset
//   z_valid   in   result strobe, sampled only in IDLE
//   opcode    in   5-bit ALU opcode
//   z         in   2*DATA_W ALU result
//   dest      in   REG_AW destination GPR index
//   wb_ready  in   register file accepts the write this cycle
//   rf_we     out  GPR write request
//   rf_waddr  out  GPR write index
//   wb_data   out  shared write data (GPR/PC/MAR)
//   pc_we     out  PC load strobe
//   mar_we    out  MAR load strobe
//   hi_out    out  HI register
//   lo_out    out  LO register
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse
//
// Handshake: the GPR write is a request/ready pair. rf_we is held together
// with stable rf_waddr/wb_data until a cycle where wb_ready=1; the write
// transfers on that rising edge. PC/MAR strobes are single-cycle and have no
// handshake.
//
// Optional feature (macro R0_LOCK_EN): when defined, GPR-class ops with
// dest=0 skip the register-file write and complete without waiting for
// wb_ready. When undefined, r0 is written like any other GPR.
// ---------------------------------------------------------------------------
module alu_result_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                z_valid,
  input  logic [4:0]          opcode,
  input  logic [2*DATA_W-1:0] z,
  input  logic [REG_AW-1:0]   dest,
  input  logic                wb_ready,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   wb_data,
  output logic                pc_we,
  output logic                mar_we,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out,
  output logic                busy,
  output logic                done
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_LOADI  = 5'b00001;
  localparam logic [4:0] OP_STORE  = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_ORI    = 5'b01110;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_NEG    = 5'b10001;
  localparam logic [4:0] OP_NOT    = 5'b10010;
  localparam logic [4:0] OP_BRANCH = 5'b10011;
  localparam logic [4:0] OP_MFHI   = 5'b11000;
  localparam logic [4:0] OP_MFLO   = 5'b11001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_NONE,    // nop/halt/out/jr/jal/in and undefined codes
    C_GPR,
    C_MEM,
    C_BR,
    C_MULDIV
  } cls_t;

  function automatic cls_t classify(input logic [4:0] op);
    cls_t c;
    c = C_NONE;
    if (op == OP_LOAD || op == OP_STORE)            c = C_MEM;
    else if (op == OP_BRANCH)                       c = C_BR;
    else if (op == OP_MUL || op == OP_DIV)          c = C_MULDIV;
    else if (op == OP_LOADI ||
             (op >= OP_ADD && op <= OP_ORI) ||
             op == OP_NEG || op == OP_NOT ||
             op == OP_MFHI || op == OP_MFLO)        c = C_GPR;
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic [4:0]          opcode_q, opcode_d;
  logic [REG_AW-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  cls_t cls_in;
  cls_t cls_q;
  logic r0_skip;

  assign cls_in = classify(opcode);
  assign cls_q  = classify(opcode_q);

`ifdef R0_LOCK_EN
  assign r0_skip = (cls_q == C_GPR) && (dest_q == '0);
`else
  assign r0_skip = 1'b0;
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    z_d      = z_q;
    opcode_d = opcode_q;
    dest_d   = dest_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (z_valid) begin
          z_d      = z;
          opcode_d = opcode;
          dest_d   = dest;
          case (cls_in)
            C_MULDIV: state_d = S_WR_LO;
            C_NONE:   state_d = S_DONE;
            default:  state_d = S_WRITE;
          endcase
        end
      end
      S_WRITE: begin
        // GPR writes wait for the handshake; PC/MAR strobes last one cycle.
        if (cls_q != C_GPR || r0_skip || wb_ready) state_d = S_DONE;
      end
      S_WR_LO: begin
        lo_d    = z_q[DATA_W-1:0];
        state_d = S_WR_HI;
      end
      S_WR_HI: begin
        hi_d    = z_q[2*DATA_W-1:DATA_W];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      z_q      <= '0;
      opcode_q <= '0;
      dest_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      z_q      <= z_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Moore output decode: functions of state and latched fields only, so a
  // reset drops every strobe in the same instant the state returns to IDLE.
  always_comb begin
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    mar_we   = 1'b0;
    rf_waddr = '0;
    wb_data  = '0;
    if (state_q == S_WRITE) begin
      rf_waddr = dest_q;
      if (opcode_q == OP_MFHI)      wb_data = hi_q;
      else if (opcode_q == OP_MFLO) wb_data = lo_q;
      else                          wb_data = z_q[DATA_W-1:0];
      rf_we  = (cls_q == C_GPR) && !r0_skip;
      pc_we  = (cls_q == C_BR);
      mar_we = (cls_q == C_MEM);
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_alu_result_writeback.sv
module tb_alu_result_writeback;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  localparam logic [4:0] OP_STORE  = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_ADDI   = 5'b01100;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_BRANCH = 5'b10011;
  localparam logic [4:0] OP_MFHI   = 5'b11000;
  localparam logic [4:0] OP_MFLO   = 5'b11001;
  localparam logic [4:0] OP_NOP    = 5'b11010;

  logic                clk = 1'b0;
  logic                clr;
  logic                z_valid;
  logic [4:0]          opcode;
  logic [2*DATA_W-1:0] z;
  logic [REG_AW-1:0]   dest;
  logic                wb_ready;
  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   wb_data;
  logic                pc_we;
  logic                mar_we;
  logic [DATA_W-1:0]   hi_out;
  logic [DATA_W-1:0]   lo_out;
  logic                busy;
  logic                done;

  int checks   = 0;
  int failures = 0;

  alu_result_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk      (clk),
    .clr      (clr),
    .z_valid  (z_valid),
    .opcode   (opcode),
    .z        (z),
    .dest     (dest),
    .wb_ready (wb_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .wb_data  (wb_data),
    .pc_we    (pc_we),
    .mar_we   (mar_we),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one result for a single accepting edge
  task automatic issue(input logic [4:0] op, input logic [63:0] zv, input logic [3:0] dst);
    opcode  = op;
    z       = zv;
    dest    = dst;
    z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
  endtask

  initial begin
    clr = 1'b1; z_valid = 1'b0; opcode = '0; z = '0; dest = '0; wb_ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    check("rst_wb_data", wb_data, 0);
    tick();
    clr = 1'b0;
    tick();

    // mul: LO then HI, done at accept+3, no GPR write
    issue(OP_MUL, 64'h1234_5678_9ABC_DEF0, 4'd1);
    check("mul_busy", busy, 1);
    check("mul_lo_before", lo_out, 0);
    check("mul_rf_we_lo", rf_we, 0);
    tick();
    check("mul_lo", lo_out, 32'h9ABC_DEF0);
    check("mul_hi_before", hi_out, 0);
    check("mul_done_early", done, 0);
    tick();
    check("mul_hi", hi_out, 32'h1234_5678);
    check("mul_done", done, 1);
    check("mul_rf_we_done", rf_we, 0);
    tick();
    check("mul_idle_busy", busy, 0);
    check("mul_idle_done", done, 0);

    // mfhi r2 / mflo r3 right after the mul
    wb_ready = 1'b1;
    issue(OP_MFHI, 64'hDEAD_BEEF_0BAD_F00D, 4'd2);
    check("mfhi_rf_we", rf_we, 1);
    check("mfhi_waddr", rf_waddr, 2);
    check("mfhi_data", wb_data, 32'h1234_5678);
    tick();
    check("mfhi_done", done, 1);
    tick();
    issue(OP_MFLO, 64'hDEAD_BEEF_0BAD_F00D, 4'd3);
    check("mflo_rf_we", rf_we, 1);
    check("mflo_waddr", rf_waddr, 3);
    check("mflo_data", wb_data, 32'h9ABC_DEF0);
    tick();
    check("mflo_done", done, 1);
    tick();

    // add r5 with three stall cycles
    wb_ready = 1'b0;
    issue(OP_ADD, 64'h0000_0000_0000_0007, 4'd5);
    for (int i = 0; i < 3; i++) begin
      check("add_stall_rf_we", rf_we, 1);
      check("add_stall_done", done, 0);
      tick();
    end
    wb_ready = 1'b1;
    check("add_rf_we", rf_we, 1);
    check("add_waddr", rf_waddr, 5);
    check("add_data", wb_data, 32'h7);
    tick();
    check("add_done", done, 1);
    check("add_rf_we_off", rf_we, 0);
    check("add_hi_kept", hi_out, 32'h1234_5678);
    check("add_lo_kept", lo_out, 32'h9ABC_DEF0);
    tick();
    check("add_idle_data", wb_data, 0);

    // branch, with a z_valid pulse while busy that must be dropped
    issue(OP_BRANCH, 64'hFFFF_0000_0000_0040, 4'd0);
    check("br_pc_we", pc_we, 1);
    check("br_data", wb_data, 32'h40);
    check("br_rf_we", rf_we, 0);
    check("br_mar_we", mar_we, 0);
    z_valid = 1'b1; opcode = OP_ADD; z = 64'h99; dest = 4'd7;
    tick();
    check("br_pc_we_off", pc_we, 0);
    check("br_done", done, 1);
    tick();
    z_valid = 1'b0;
    check("busy_ignore_idle", busy, 0);
    tick();
    check("busy_ignore_no_txn", busy, 0);
    check("busy_ignore_rf_we", rf_we, 0);

    // store
    issue(OP_STORE, 64'h0000_0001_0000_0087, 4'd0);
    check("st_mar_we", mar_we, 1);
    check("st_data", wb_data, 32'h87);
    check("st_pc_we", pc_we, 0);
    tick();
    check("st_mar_we_off", mar_we, 0);
    check("st_done", done, 1);
    tick();

    // nop: done at accept+1
    issue(OP_NOP, 64'h5, 4'd4);
    check("nop_done", done, 1);
    check("nop_rf_we", rf_we, 0);
    tick();
    check("nop_idle", busy, 0);

    // addi r0 with wb_ready low
    wb_ready = 1'b0;
    issue(OP_ADDI, 64'h0000_0000_0000_0033, 4'd0);
`ifdef R0_LOCK_EN
    check("r0_rf_we", rf_we, 0);
    tick();
    check("r0_done", done, 1);
    tick();
`else
    check("r0_rf_we", rf_we, 1);
    check("r0_data", wb_data, 32'h33);
    tick();
    check("r0_rf_we_hold", rf_we, 1);
    check("r0_no_done", done, 0);
    wb_ready = 1'b1;
    tick();
    check("r0_done", done, 1);
    tick();
`endif

    // reset in the middle of WR_LO of a mul
    issue(OP_MUL, 64'hAAAA_BBBB_CCCC_DDDD, 4'd1);
    #2;
    clr = 1'b1;
    #1;
    check("clr_hi", hi_out, 0);
    check("clr_lo", lo_out, 0);
    check("clr_busy", busy, 0);
    check("clr_rf_we", rf_we, 0);
    check("clr_done", done, 0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_after_done", done, 0);
      check("clr_after_lo", lo_out, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
